// File: rtl/ex_div.sv
// RV32M multi-cycle divider for the execute stage.
// Radix-2 restoring division on magnitudes, sign-corrected on completion.
module ex_div #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   dividend_i,
  input  logic [XLEN-1:0]   divisor_i,
  input  logic [REG_AW-1:0] reg_waddr_i,
  input  logic              flush_i,
  output logic [XLEN-1:0]   result_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic [REG_AW-1:0] reg_waddr_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] dsr;
  logic [CW-1:0]   count;
  logic            q_neg;
  logic            r_neg;
  logic            is_rem;

  logic            op_sgn;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div0;
  logic [XLEN-1:0] zero_res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quot_n;
  logic [XLEN-1:0] fin;
  logic            last;

  // Any funct3 outside 1xx decodes as DIVU.
  assign op_sgn   = op_i[2] & ~op_i[0];
  assign op_rem   = op_i[2] & op_i[1];
  assign a_neg    = op_sgn & dividend_i[XLEN-1];
  assign b_neg    = op_sgn & divisor_i[XLEN-1];
  assign a_mag    = a_neg ? -dividend_i : dividend_i;
  assign b_mag    = b_neg ? -divisor_i : divisor_i;
  assign div0     = (divisor_i == '0);
  assign zero_res = op_rem ? dividend_i : '1;

  // Extra top bit keeps the compare exact for divisors >= 2^(XLEN-1).
  assign rem_sh = {rem, quot[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dsr};
  assign ge     = ~diff[XLEN];
  assign rem_n  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_n = {quot[XLEN-2:0], ge};
  assign last   = (count == CW'(XLEN - 1));

  always_comb begin
    fin = q_neg ? -quot_n : quot_n;
    if (is_rem) begin
      fin = r_neg ? -rem_n : rem_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state_nxt = div0 ? DONE : CALC;
          end
        end
        CALC: begin
          if (last) begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      quot        <= '0;
      dsr         <= '0;
      count       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      is_rem      <= 1'b0;
      result_o    <= '0;
      reg_waddr_o <= '0;
    end else if (!flush_i) begin
      if (state == IDLE && start_i) begin
        rem         <= '0;
        quot        <= a_mag;
        dsr         <= b_mag;
        count       <= '0;
        q_neg       <= a_neg ^ b_neg;
        r_neg       <= a_neg;
        is_rem      <= op_rem;
        reg_waddr_o <= reg_waddr_i;
        if (div0) begin
          result_o <= zero_res;
        end
      end else if (state == CALC) begin
        rem   <= rem_n;
        quot  <= quot_n;
        count <= count + CW'(1);
        if (last) begin
          result_o <= fin;
        end
      end
    end
  end

  assign ready_o = (state == DONE);
  assign busy_o  = (state == CALC);

endmodule

// File: tb/tb_ex_div.sv
// Randomised and directed checks of ex_div against an arithmetic model.
// Model tracks op timing and computes results with 64-bit integer math.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  reg_waddr_o;

  int n_assert = 0;
  int n_fail = 0;

  ex_div dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .op_i(op_i),
    .dividend_i(dividend_i),
    .divisor_i(divisor_i),
    .reg_waddr_i(reg_waddr_i),
    .flush_i(flush_i),
    .result_o(result_o),
    .ready_o(ready_o),
    .busy_o(busy_o),
    .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic   sg;
    logic   rm;
    longint sa;
    longint sb;
    longint q;
    longint r;
    sg = (op == 3'b100) || (op == 3'b110);
    rm = (op == 3'b110) || (op == 3'b111);
    if (b == 32'h0) return rm ? a : 32'hFFFF_FFFF;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return rm ? r[31:0] : q[31:0];
  endfunction

  // Model: 0 idle, 1 computing (m_cnt cycles left), 2 result cycle.
  int          m_mode = 0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_wa = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_res  = '0;
      m_wa   = '0;
    end else if (flush_i) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (start_i) begin
          m_wa   = reg_waddr_i;
          m_pend = ref_div(op_i, dividend_i, divisor_i);
          if (divisor_i == 32'h0) begin
            m_mode = 2;
            m_res  = m_pend;
          end else begin
            m_mode = 1;
            m_cnt  = 32;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_mode = 2;
            m_res  = m_pend;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'b0, busy_o}, {31'b0, m_mode == 1});
    chk("ready", {31'b0, ready_o}, {31'b0, m_mode == 2});
    chk("result", result_o, m_res);
    chk("waddr", {27'b0, reg_waddr_o}, {27'b0, m_wa});
  end

  task automatic run_op(input string nm, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat,
                        input bit junk);
    int n;
    @(negedge clk);
    start_i     = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = 5'($urandom);
    @(negedge clk);
    start_i = 1'b0;
    n = 1;
    while (!ready_o && n < 40) begin
      if (junk) begin
        start_i    = 1'($urandom);
        dividend_i = $urandom;
        divisor_i  = $urandom;
        op_i       = 3'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_res"}, result_o, exp);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    repeat (2) @(negedge clk);
    chk("rst_result", result_o, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_ready", {31'b0, ready_o}, 32'h0);
    rst = 1'b0;

    run_op("div_100_7", 3'b100, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("rem_m100_7", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 1'b0);
    run_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, 33, 1'b0);

    // Abort mid-divide, then a flush racing a start in IDLE.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b101; dividend_i = 32'd50; divisor_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", {31'b0, busy_o}, 32'h0);
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", {31'b0, busy_o}, 32'h0);
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 33, 1'b1);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b100; dividend_i = 32'd77; divisor_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_result", result_o, 32'h0);
    chk("arst_busy", {31'b0, busy_o}, 32'h0);
    chk("arst_ready", {31'b0, ready_o}, 32'h0);
    chk("arst_waddr", {27'b0, reg_waddr_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("div_m9_2", 3'b100, 32'hFFFF_FFF7, 32'd2, 32'hFFFF_FFFC, 33, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 300);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, ref_div(op, a, b), (b == 0) ? 1 : 33, 1'(i % 2));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
